// File: rtl/nios2_mul_seq_ctrl.sv
// Sequential 32x32->64 multiplier for the Nios II mul/mulx* family, built around one shared
// 16x16 unsigned partial-product multiplier with a tagged return pipeline.
module nios2_mul_seq_ctrl #(
  parameter int unsigned PP_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  in_op,
  input  logic [31:0] in_src1,
  input  logic [31:0] in_src2,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result_hi,
  output logic [31:0] out_result_lo
);

  typedef enum logic [2:0] {StIdle, StIssue, StDrain, StCorrect, StHold} state_e;

  localparam int unsigned DrainLastInt = (PP_LATENCY > 1) ? PP_LATENCY - 2 : 0;
  localparam logic [1:0]  DrainLast    = DrainLastInt[1:0];

  state_e      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] a_q, a_d, b_q, b_d;
  logic [1:0]  op_q, op_d;
  logic [63:0] acc_q, acc_d;
  logic        in_ready_q, in_ready_d;
  logic        out_valid_q, out_valid_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;

  logic [PP_LATENCY-1:0][31:0] pp_q, pp_d;
  logic [PP_LATENCY-1:0][1:0]  tag_q, tag_d;
  logic [PP_LATENCY-1:0]       ppv_q, ppv_d;

  logic [15:0] mul_a, mul_b;
  logic [31:0] pp_ret;
  logic [1:0]  tag_ret;
  logic [63:0] pp_shift;
  logic [31:0] corr_a, corr_b, corr;

  // Issue order by count: 0 lo*lo, 1 hi*lo, 2 lo*hi, 3 hi*hi.
  always_comb begin
    mul_a = cnt_q[0] ? a_q[31:16] : a_q[15:0];
    mul_b = cnt_q[1] ? b_q[31:16] : b_q[15:0];
    pp_d  = pp_q;
    tag_d = tag_q;
    ppv_d = ppv_q;
    pp_d[0]  = {16'b0, mul_a} * {16'b0, mul_b};
    tag_d[0] = cnt_q;
    ppv_d[0] = (state_q == StIssue);
    for (int unsigned k = 1; k < PP_LATENCY; k++) begin
      pp_d[k]  = pp_q[k-1];
      tag_d[k] = tag_q[k-1];
      ppv_d[k] = ppv_q[k-1];
    end
    pp_ret  = pp_q[PP_LATENCY-1];
    tag_ret = tag_q[PP_LATENCY-1];
    case (tag_ret)
      2'd0:    pp_shift = {32'b0, pp_ret};
      2'd3:    pp_shift = {pp_ret, 32'b0};
      default: pp_shift = {16'b0, pp_ret, 16'b0};
    endcase
  end

  // Signed operands are handled by subtracting the two's-complement weight from the high word.
  always_comb begin
    corr_a = (op_q[1] && a_q[31]) ? b_q : 32'b0;
    corr_b = ((op_q == 2'b11) && b_q[31]) ? a_q : 32'b0;
    corr   = corr_a + corr_b;
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    a_d         = a_q;
    b_d         = b_q;
    op_d        = op_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    acc_d       = acc_q;
    if (ppv_q[PP_LATENCY-1]) begin
      acc_d = acc_q + pp_shift;
    end
    if (state_q == StCorrect) begin
      acc_d = acc_d - {corr, 32'b0};
    end
    unique case (state_q)
      StIdle: begin
        if (in_valid && in_ready_q) begin
          a_d        = in_src1;
          b_d        = in_src2;
          op_d       = in_op;
          acc_d      = '0;
          cnt_d      = 2'd0;
          in_ready_d = 1'b0;
          state_d    = StIssue;
        end
      end
      StIssue: begin
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == 2'd3) begin
          cnt_d   = 2'd0;
          state_d = (PP_LATENCY > 1) ? StDrain : StCorrect;
        end
      end
      StDrain: begin
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == DrainLast) begin
          cnt_d   = 2'd0;
          state_d = StCorrect;
        end
      end
      StCorrect: begin
        state_d = StHold;
      end
      StHold: begin
        if (!out_valid_q) begin
          out_valid_d = 1'b1;
          hi_d        = acc_q[63:32];
          lo_d        = acc_q[31:0];
        end else if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= '0;
      acc_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      hi_q        <= '0;
      lo_q        <= '0;
      pp_q        <= '0;
      tag_q       <= '0;
      ppv_q       <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      a_q         <= a_d;
      b_q         <= b_d;
      op_q        <= op_d;
      acc_q       <= acc_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
      pp_q        <= pp_d;
      tag_q       <= tag_d;
      ppv_q       <= ppv_d;
    end
  end

  assign in_ready      = in_ready_q;
  assign out_valid     = out_valid_q;
  assign out_result_hi = hi_q;
  assign out_result_lo = lo_q;

endmodule

// File: tb/tb_nios2_mul_seq_ctrl.sv
// Scoreboard bench for nios2_mul_seq_ctrl: one lane per PP_LATENCY (1 and 2), each with its own
// driver, queue of expected products and monitor, checked against a plain 64-bit product model.
module tb_nios2_mul_seq_ctrl;

  typedef struct {
    logic [63:0] res;
    time         t;
  } exp_t;

  typedef struct packed {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] res;
  } dir_t;

  localparam dir_t Dirs [8] = '{
    '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001},
    '{2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_0000_0001},
    '{2'b11, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000},
    '{2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFF_0000_0001},
    '{2'b00, 32'h1234_5678, 32'h0000_0010, 64'h0000_0001_2345_6780},
    '{2'b10, 32'h8000_0000, 32'h0000_0002, 64'hFFFF_FFFF_0000_0000},
    '{2'b11, 32'h0000_0003, 32'hFFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFA},
    '{2'b10, 32'h0000_0005, 32'hFFFF_FFFF, 64'h0000_0004_FFFF_FFFB}
  };

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  bit done [2];

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] req);
    n_checks++;
    if (got !== req) begin
      n_errors++;
      $display("FAIL %s: got %h, required %h", nm, got, req);
    end
  endtask

  // Full mathematical product, truncated to 64 bits.
  function automatic logic [63:0] ref_mul(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    longint x;
    longint y;
    x = op[1] ? longint'(signed'(a)) : longint'({32'b0, a});
    y = (op == 2'b11) ? longint'(signed'(b)) : longint'({32'b0, b});
    return 64'(x * y);
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'h7FFF_FFFF;
      default: return $urandom();
    endcase
  endfunction

  for (genvar g = 0; g < 2; g++) begin : lane
    localparam int unsigned Lat = g + 1;

    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_op;
    logic [31:0] in_src1;
    logic [31:0] in_src2;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] hi;
    logic [31:0] lo;
    bit          rnd_rdy;
    bit          force_rdy;
    exp_t        exp_q [$];
    exp_t        cur;
    bit          has_cur;
    bit          vld_prev;

    nios2_mul_seq_ctrl #(
      .PP_LATENCY(Lat)
    ) u_dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_op        (in_op),
      .in_src1      (in_src1),
      .in_src2      (in_src2),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_result_hi(hi),
      .out_result_lo(lo)
    );

    always @(posedge clk) begin
      #1;
      out_ready = rnd_rdy ? ($urandom_range(0, 3) != 0) : force_rdy;
    end

    // Monitor: pops an expectation on each rising out_valid, then holds it while valid.
    always @(negedge clk) begin
      if (!reset_n) begin
        has_cur  = 1'b0;
        vld_prev = 1'b0;
      end else begin
        if (out_valid && !vld_prev) begin
          if (exp_q.size() == 0) begin
            has_cur = 1'b0;
            chk($sformatf("L%0d spurious out_valid", Lat), 64'(out_valid), 64'd0);
          end else begin
            cur     = exp_q.pop_front();
            has_cur = 1'b1;
            chk($sformatf("L%0d latency edges", Lat), 64'(($time - 5 - cur.t) / 10),
                64'(5 + Lat));
          end
        end
        if (out_valid && has_cur) begin
          chk($sformatf("L%0d result", Lat), {hi, lo}, cur.res);
        end
        vld_prev = out_valid;
      end
    end

    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] exp_res);
      int n = 0;
      in_valid = 1'b1;
      in_op    = op;
      in_src1  = a;
      in_src2  = b;
      while (!in_ready && n < 300) begin
        @(negedge clk);
        n++;
      end
      if (!in_ready) begin
        chk($sformatf("L%0d accept timeout", Lat), 64'(in_ready), 64'd1);
        in_valid = 1'b0;
      end else begin
        @(posedge clk);
        exp_q.push_back('{res: exp_res, t: $time});
        @(negedge clk);
        in_valid = 1'b0;
        in_op    = 2'($urandom());
        in_src1  = $urandom();
        in_src2  = $urandom();
      end
    endtask

    task automatic drain();
      int n = 0;
      while ((exp_q.size() != 0 || !in_ready) && n < 300) begin
        @(negedge clk);
        n++;
      end
    endtask

    initial begin
      int          n;
      logic [1:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      reset_n   = 1'b0;
      in_valid  = 1'b0;
      in_op     = 2'b00;
      in_src1   = '0;
      in_src2   = '0;
      rnd_rdy   = 1'b0;
      force_rdy = 1'b1;
      repeat (3) @(negedge clk);
      chk($sformatf("L%0d reset in_ready", Lat), 64'(in_ready), 64'd1);
      chk($sformatf("L%0d reset out_valid", Lat), 64'(out_valid), 64'd0);
      chk($sformatf("L%0d reset result", Lat), {hi, lo}, 64'd0);
      reset_n = 1'b1;
      @(negedge clk);

      foreach (Dirs[i]) begin
        issue(Dirs[i].op, Dirs[i].a, Dirs[i].b, Dirs[i].res);
        repeat (i % 3) @(negedge clk);
      end

      // Backpressure: result held, second request stalled until acceptance.
      drain();
      force_rdy = 1'b0;
      issue(2'b11, 32'h0000_1234, 32'hFFFF_FFF0, 64'hFFFF_FFFF_FFFE_DCC0);
      in_valid = 1'b1;
      in_op    = 2'b01;
      in_src1  = 32'hDEAD_BEEF;
      in_src2  = 32'h0000_0002;
      n = 0;
      while (!out_valid && n < 50) begin
        @(negedge clk);
        n++;
      end
      chk($sformatf("L%0d bp out_valid", Lat), 64'(out_valid), 64'd1);
      repeat (10) begin
        @(negedge clk);
        chk($sformatf("L%0d bp in_ready", Lat), 64'(in_ready), 64'd0);
      end
      force_rdy = 1'b1;
      n = 0;
      while (out_valid && n < 20) begin
        @(negedge clk);
        n++;
      end
      chk($sformatf("L%0d in_ready after accept", Lat), 64'(in_ready), 64'd1);
      issue(2'b01, 32'hDEAD_BEEF, 32'h0000_0002, 64'h0000_0001_BD5B_7DDE);

      // Reset in the middle of ISSUE discards the in-flight product.
      issue(2'b11, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000);
      @(negedge clk);
      reset_n = 1'b0;
      #1;
      chk($sformatf("L%0d mid-op reset out_valid", Lat), 64'(out_valid), 64'd0);
      chk($sformatf("L%0d mid-op reset in_ready", Lat), 64'(in_ready), 64'd1);
      chk($sformatf("L%0d mid-op reset result", Lat), {hi, lo}, 64'd0);
      void'(exp_q.pop_back());
      @(negedge clk);
      reset_n = 1'b1;
      repeat (20) @(negedge clk);
      chk($sformatf("L%0d post-reset out_valid", Lat), 64'(out_valid), 64'd0);
      chk($sformatf("L%0d post-reset in_ready", Lat), 64'(in_ready), 64'd1);

      rnd_rdy = 1'b1;
      for (int i = 0; i < 1000; i++) begin
        op = 2'($urandom());
        a  = pick();
        b  = pick();
        issue(op, a, b, ref_mul(op, a, b));
        repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      rnd_rdy = 1'b0;
      drain();
      chk($sformatf("L%0d queue drained", Lat), 64'(exp_q.size()), 64'd0);
      chk($sformatf("L%0d idle at end", Lat), 64'(in_ready), 64'd1);
      done[g] = 1'b1;
    end
  end

  initial begin
    wait (done[0] && done[1]);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: got no completion, required completion within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
